// File: rtl/trace_event_player_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : trace_event_player_if                                          |
// | Brief    : Load/control/playback bus for trace_event_player.              |
// |            TRACE_PLAYER_LOOP_EN adds the loop/wraps signals.               |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
interface trace_event_player_if #(
  parameter int CHANNELS = 1,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 16,
  parameter int DELTA_W  = 16
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                       en;
  logic                       load_valid;
  logic                       load_ready;
  logic [DELTA_W-1:0]         load_delta;
  logic [CHANNELS-1:0]        load_mask;
  logic [CHANNELS*DATA_W-1:0] load_data;
  logic                       start;
  logic                       clear;
  logic                       busy;
  logic                       done;
  logic [CHANNELS*DATA_W-1:0] input_data;
  logic [CHANNELS-1:0]        new_input;
  logic [CNT_W-1:0]           event_count;
`ifdef TRACE_PLAYER_LOOP_EN
  logic                       loop;
  logic [15:0]                wraps;

  modport master (
    output en, load_valid, load_delta, load_mask, load_data, start, clear, loop,
    input  load_ready, busy, done, input_data, new_input, event_count, wraps
  );
  modport slave (
    input  en, load_valid, load_delta, load_mask, load_data, start, clear, loop,
    output load_ready, busy, done, input_data, new_input, event_count, wraps
  );
`else
  modport master (
    output en, load_valid, load_delta, load_mask, load_data, start, clear,
    input  load_ready, busy, done, input_data, new_input, event_count
  );
  modport slave (
    input  en, load_valid, load_delta, load_mask, load_data, start, clear,
    output load_ready, busy, done, input_data, new_input, event_count
  );
`endif
endinterface
`default_nettype wire

// File: rtl/trace_event_player.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : trace_event_player                                             |
// | Brief    : Replays stored timestamped events as one-cycle input strobes.  |
// |            Define TRACE_PLAYER_LOOP_EN for looped playback.               |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module trace_event_player #(
  parameter int CHANNELS = 1,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 16,
  parameter int DELTA_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  trace_event_player_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BUS_W = CHANNELS * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DELTA_W-1:0]  cnt_q, cnt_d;
  logic                fire_q, fire_d;
  logic [CHANNELS-1:0] new_input_q, new_input_d;
  logic [BUS_W-1:0]    input_data_q, input_data_d;
`ifdef TRACE_PLAYER_LOOP_EN
  logic [15:0]         wraps_q, wraps_d;
`endif

  logic                load_ready;
  logic                load_we;
  logic                fire;
  logic                is_last;
  logic [PTR_W-1:0]    rd_next;

  logic [DELTA_W-1:0]  delta_mem [DEPTH];
  logic [CHANNELS-1:0] mask_mem  [DEPTH];
  logic [BUS_W-1:0]    data_mem  [DEPTH];

  assign load_ready = (state_q == S_IDLE) && (count_q < CNT_W'(DEPTH));
  assign rd_next    = rd_ptr_q + PTR_W'(1);
  assign is_last    = (CNT_W'(rd_ptr_q) + CNT_W'(1)) == count_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    load_we  = 1'b0;
    fire     = 1'b0;
`ifdef TRACE_PLAYER_LOOP_EN
    wraps_d  = wraps_q;
`endif
    if (bus.clear) begin
      state_d  = S_IDLE;
      count_d  = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
`ifdef TRACE_PLAYER_LOOP_EN
      wraps_d  = '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.load_valid && load_ready) begin
            load_we = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
          if (bus.start && (count_q != '0)) begin
            state_d  = S_COUNT;
            rd_ptr_d = '0;
            cnt_d    = delta_mem[0];
`ifdef TRACE_PLAYER_LOOP_EN
            wraps_d  = '0;
`endif
          end
        end
        S_COUNT: begin
          if (bus.en) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - DELTA_W'(1);
            end else begin
              fire = 1'b1;
              if (!is_last) begin
                rd_ptr_d = rd_next;
                cnt_d    = delta_mem[rd_next];
              end
`ifdef TRACE_PLAYER_LOOP_EN
              else if (bus.loop) begin
                rd_ptr_d = '0;
                cnt_d    = delta_mem[0];
                if (wraps_q != 16'hFFFF) wraps_d = wraps_q + 16'd1;
              end
`endif
              else begin
                state_d  = S_DONE;
                rd_ptr_d = '0;
              end
            end
          end
        end
        S_DONE: begin
          if (bus.start) begin
            state_d  = S_COUNT;
            rd_ptr_d = '0;
            cnt_d    = delta_mem[0];
`ifdef TRACE_PLAYER_LOOP_EN
            wraps_d  = '0;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output stage: strobe and masked data are registered so they appear the cycle after the fire decision.
  always_comb begin
    fire_d       = fire;
    new_input_d  = '0;
    input_data_d = '0;
    if (fire) begin
      new_input_d = mask_mem[rd_ptr_q];
      for (int k = 0; k < CHANNELS; k++) begin
        if (mask_mem[rd_ptr_q][k])
          input_data_d[k*DATA_W +: DATA_W] = data_mem[rd_ptr_q][k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      fire_q       <= 1'b0;
      new_input_q  <= '0;
      input_data_q <= '0;
`ifdef TRACE_PLAYER_LOOP_EN
      wraps_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      fire_q       <= fire_d;
      new_input_q  <= new_input_d;
      input_data_q <= input_data_d;
`ifdef TRACE_PLAYER_LOOP_EN
      wraps_q      <= wraps_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      delta_mem[count_q[PTR_W-1:0]] <= bus.load_delta;
      mask_mem[count_q[PTR_W-1:0]]  <= bus.load_mask;
      data_mem[count_q[PTR_W-1:0]]  <= bus.load_data;
    end
  end

  // The FSM leaves COUNT on the fire decision, one cycle before the strobe shows; hide that lag.
  assign bus.busy        = (state_q == S_COUNT) || fire_q;
  assign bus.done        = (state_q == S_DONE) && !fire_q;
  assign bus.load_ready  = load_ready;
  assign bus.new_input   = new_input_q;
  assign bus.input_data  = input_data_q;
  assign bus.event_count = count_q;
`ifdef TRACE_PLAYER_LOOP_EN
  assign bus.wraps       = wraps_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_trace_event_player.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_trace_event_player                                          |
// | Brief    : Directed self-checking bench for trace_event_player.           |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module tb_trace_event_player;
  localparam int CH  = 2;
  localparam int DW  = 16;
  localparam int DP  = 4;
  localparam int DLW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  trace_event_player_if #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DP), .DELTA_W(DLW)) bus ();

  trace_event_player #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DP), .DELTA_W(DLW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [DLW-1:0] d, input logic [CH-1:0] m, input logic [CH*DW-1:0] x);
    bus.load_valid = 1'b1;
    bus.load_delta = d;
    bus.load_mask  = m;
    bus.load_data  = x;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bus.new_input !== 2'b00 || bus.input_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: new_input=%b input_data=%h, want 0/0", i, bus.new_input, bus.input_data);
      end
      checks++;
      if (bus.load_ready !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.event_count !== 3'd0) begin
        errors++;
        $display("FAIL reset_ctrl cyc %0d: ready=%b done=%b busy=%b count=%0d, want 1/0/0/0",
                 i, bus.load_ready, bus.done, bus.busy, bus.event_count);
      end
    end
  endtask

  task automatic test_playback();
    logic [1:0]  exp_ni;
    logic [31:0] exp_d;
    pulse_clear();
    do_load(8'd3, 2'b01, {16'hA5A5, 16'd1});
    do_load(8'd0, 2'b01, {16'hA5A5, 16'd2});
    do_load(8'd2, 2'b01, {16'hA5A5, 16'd3});
    checks++;
    if (bus.event_count !== 3'd3) begin
      errors++;
      $display("FAIL playback_count: got %0d want 3", bus.event_count);
    end
    bus.start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) bus.start = 1'b0;
      exp_ni = (i == 5 || i == 6 || i == 9) ? 2'b01 : 2'b00;
      exp_d  = (i == 5) ? 32'd1 : (i == 6) ? 32'd2 : (i == 9) ? 32'd3 : 32'd0;
      checks++;
      if (bus.new_input !== exp_ni || bus.input_data !== exp_d) begin
        errors++;
        $display("FAIL playback S+%0d: new_input=%b data=%h, want %b %h", i, bus.new_input, bus.input_data, exp_ni, exp_d);
      end
      if (i == 9 || i == 10) begin
        checks++;
        if (bus.done !== (i == 10) || bus.busy !== (i == 9)) begin
          errors++;
          $display("FAIL playback_done S+%0d: done=%b busy=%b, want %b %b", i, bus.done, bus.busy, i == 10, i == 9);
        end
      end
    end
  endtask

  task automatic test_en_stall();
    logic [1:0]  exp_ni;
    logic [31:0] exp_d;
    bus.start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 1) bus.start = 1'b0;
      exp_ni = (i == 9 || i == 10 || i == 13) ? 2'b01 : 2'b00;
      exp_d  = (i == 9) ? 32'd1 : (i == 10) ? 32'd2 : (i == 13) ? 32'd3 : 32'd0;
      checks++;
      if (bus.new_input !== exp_ni || bus.input_data !== exp_d) begin
        errors++;
        $display("FAIL en_stall S+%0d: new_input=%b data=%h, want %b %h", i, bus.new_input, bus.input_data, exp_ni, exp_d);
      end
      if (i == 13 || i == 14) begin
        checks++;
        if (bus.done !== (i == 14)) begin
          errors++;
          $display("FAIL en_stall_done S+%0d: done=%b want %b", i, bus.done, i == 14);
        end
      end
      bus.en = !(i >= 3 && i <= 6);
    end
    bus.en = 1'b1;
  endtask

  task automatic test_mask();
    logic [1:0]  exp_ni;
    logic [31:0] exp_d;
    pulse_clear();
    checks++;
    if (bus.event_count !== 3'd0 || bus.load_ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL clear: count=%0d ready=%b done=%b, want 0 1 0", bus.event_count, bus.load_ready, bus.done);
    end
    do_load(8'd1, 2'b10, {16'd9, 16'd7});
    do_load(8'd0, 2'b00, {16'hFFFF, 16'hFFFF});
    do_load(8'd0, 2'b11, {16'd5, 16'd6});
    bus.start = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 1) bus.start = 1'b0;
      exp_ni = (i == 3) ? 2'b10 : (i == 5) ? 2'b11 : 2'b00;
      exp_d  = (i == 3) ? {16'd9, 16'd0} : (i == 5) ? {16'd5, 16'd6} : 32'd0;
      checks++;
      if (bus.new_input !== exp_ni || bus.input_data !== exp_d) begin
        errors++;
        $display("FAIL mask S+%0d: new_input=%b data=%h, want %b %h", i, bus.new_input, bus.input_data, exp_ni, exp_d);
      end
      if (i == 6) begin
        checks++;
        if (bus.done !== 1'b1) begin
          errors++;
          $display("FAIL mask_done: done=%b want 1", bus.done);
        end
      end
    end
  endtask

  task automatic test_full();
    int          accepted;
    logic [1:0]  exp_ni;
    logic [31:0] exp_d;
    accepted = 0;
    pulse_clear();
    bus.load_valid = 1'b1;
    for (int a = 0; a < 6; a++) begin
      bus.load_delta = 8'd0;
      bus.load_mask  = 2'b01;
      bus.load_data  = 32'(11 + a);
      if (bus.load_ready) accepted++;
      step();
    end
    bus.load_valid = 1'b0;
    checks++;
    if (accepted != 4 || bus.event_count !== 3'd4 || bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: accepted=%0d count=%0d ready=%b, want 4 4 0", accepted, bus.event_count, bus.load_ready);
    end
    bus.start = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 1) bus.start = 1'b0;
      exp_ni = (i >= 2 && i <= 5) ? 2'b01 : 2'b00;
      exp_d  = (i >= 2 && i <= 5) ? 32'(9 + i) : 32'd0;
      checks++;
      if (bus.new_input !== exp_ni || bus.input_data !== exp_d) begin
        errors++;
        $display("FAIL full_play S+%0d: new_input=%b data=%h, want %b %h", i, bus.new_input, bus.input_data, exp_ni, exp_d);
      end
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL full_done: done=%b want 1", bus.done);
    end
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.new_input !== 2'b00 || bus.input_data !== 32'h0 || bus.event_count !== 3'd0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: ni=%b data=%h count=%0d busy=%b done=%b ready=%b, want 0 0 0 0 0 1",
               bus.new_input, bus.input_data, bus.event_count, bus.busy, bus.done, bus.load_ready);
    end
    rst_n = 1'b1;
    step();
    bus.start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) bus.start = 1'b0;
      checks++;
      if (bus.new_input !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL empty_start S+%0d: ni=%b busy=%b done=%b, want 0 0 0", i, bus.new_input, bus.busy, bus.done);
      end
    end
  endtask

`ifdef TRACE_PLAYER_LOOP_EN
  task automatic test_loop();
    logic [1:0]  exp_ni;
    logic [31:0] exp_d;
    logic [15:0] exp_w;
    bit          seen_done;
    pulse_clear();
    do_load(8'd1, 2'b01, {16'd0, 16'd21});
    do_load(8'd1, 2'b01, {16'd0, 16'd22});
    bus.loop  = 1'b1;
    bus.start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) bus.start = 1'b0;
      exp_ni = (i >= 3 && (i % 2) == 1) ? 2'b01 : 2'b00;
      exp_d  = (exp_ni == 2'b01) ? (((i - 3) % 4 == 0) ? 32'd21 : 32'd22) : 32'd0;
      exp_w  = (i >= 5) ? 16'((i - 1) / 4) : 16'd0;
      checks++;
      if (bus.new_input !== exp_ni || bus.input_data !== exp_d || bus.wraps !== exp_w) begin
        errors++;
        $display("FAIL loop S+%0d: ni=%b data=%h wraps=%0d, want %b %h %0d",
                 i, bus.new_input, bus.input_data, bus.wraps, exp_ni, exp_d, exp_w);
      end
    end
    bus.loop  = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10 && !seen_done; i++) begin
      step();
      seen_done = bus.done;
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL loop_exit: done=%b within 10 cycles, want 1", bus.done);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en         = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_delta = '0;
    bus.load_mask  = '0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
`ifdef TRACE_PLAYER_LOOP_EN
    bus.loop       = 1'b0;
`endif
    test_reset();
    test_playback();
    test_en_stall();
    test_mask();
    test_full();
    test_reset_mid();
`ifdef TRACE_PLAYER_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
